comb64: RTL and testbench

Multi-stage, 64-bit, 1- or 2-channel comb (differentiator) cascade that forms the decimating back end of the CIC filters in the receive chain. It accepts decimated 64-bit samples from the integrator section on a valid strobe and differences each sample against the previous sample of the same channel in every stage. It then reduces the result to the output width and emits it with a valid strobe and a channel tag to the downstream FIR/AGC path.

---
 rtl/comb64_pkg.sv | 21 ++
 rtl/comb64_if.sv | 15 +
 rtl/comb64_stage.sv | 40 ++++
 rtl/comb64.sv | 97 +++++++++
 tb/tb_comb64.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comb64_pkg.sv
// comb64_pkg: shared constants and the sample-with-tag record used by the
// comb64 differentiator cascade.
package comb64_pkg;

    // Datapath width of the comb section (matches the integrator word).
    localparam int DATA_W = 64;

    // Legal parameter ranges.
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 6;
    localparam int OW_MIN     = 8;
    localparam int OW_MAX     = 64;

    // One sample travelling down the cascade with its valid bit and channel tag.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              ch;
    } sample_t;

endpackage

// File: rtl/comb64_if.sv
// comb64_if: sample-in / sample-out bundle of the comb64 cascade.
// master = upstream/downstream environment, slave = the comb64 block.
interface comb64_if #(
    parameter int OW = 24
) ();
    logic signed [63:0]   d;
    logic                 dv;
    logic                 n;
    logic signed [OW-1:0] q;
    logic                 qv;
    logic                 qch;

    modport master (output d, dv, n, input q, qv, qch);
    modport slave  (input d, dv, n, output q, qv, qch);
endinterface

// File: rtl/comb64_stage.sv
// comb64_stage: one differentiator stage. Subtracts the previous sample of
// the same channel (1-deep delay for a single channel, 2-deep when two
// channels are interleaved). History only advances on a valid sample.
module comb64_stage
    import comb64_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    n,
    input  sample_t x,
    output sample_t y
);

    logic signed [DATA_W-1:0] z1;
    logic signed [DATA_W-1:0] z2;
    logic signed [DATA_W-1:0] diff;

    // Modular difference against the same-channel predecessor.
    always_comb begin
        diff = $signed(x.data) - (n ? z2 : z1);
    end

    // Stage register plus delay line; advances only on valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            z1 <= '0;
            z2 <= '0;
            y  <= '0;
        end else begin
            y.valid <= x.valid;
            if (x.valid) begin
                y.data <= diff;
                y.ch   <= x.ch;
                z2     <= z1;
                z1     <= x.data;
            end
        end
    end

endmodule

// File: rtl/comb64.sv
// comb64: STAGES-deep comb (differentiator) cascade, 64-bit modular
// arithmetic, 1 or 2 interleaved channels, reduced to the top OW bits.
// Optional build macro COMB64_ROUND_EN: round half up before truncation
// (with clamp on positive overflow) when OW < 64; otherwise plain truncation.
module comb64
    import comb64_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int OW     = 24
) (
    input  logic     clk,
    input  logic     rst,
    comb64_if.slave  bus
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || OW < OW_MIN || OW > OW_MAX) begin : g_bad_cfg
        $error("comb64: STAGES or OW out of range");
    end

`ifdef COMB64_ROUND_EN
    localparam int                RSH = (OW < DATA_W) ? (DATA_W - 1 - OW) : 0;
    localparam logic [DATA_W-1:0] RND = 64'd1 << RSH;

    // Round half up, clamping a positive value that the carry would flip negative.
    function automatic logic signed [OW-1:0] round_sat(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] s;
        s = x + RND;
        if (!x[DATA_W-1] && s[DATA_W-1]) begin
            return {1'b0, {(OW-1){1'b1}}};
        end
        return s[DATA_W-1 -: OW];
    endfunction
`endif

    // Plain truncation to the top OW bits.
    function automatic logic signed [OW-1:0] trunc_q(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1 -: OW];
    endfunction

    function automatic logic signed [OW-1:0] reduce_q(input logic signed [DATA_W-1:0] x);
`ifdef COMB64_ROUND_EN
        if (OW < DATA_W) begin
            return round_sat(x);
        end
`endif
        return trunc_q(x);
    endfunction

    logic                 ch_cnt;
    sample_t              pipe [STAGES+1];
    logic signed [OW-1:0] q_o;
    logic                 qv_o;
    logic                 qch_o;

    // Input channel counter: alternates A/B per sample in two-channel mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt <= 1'b0;
        end else if (!bus.n) begin
            ch_cnt <= 1'b0;
        end else if (bus.dv) begin
            ch_cnt <= ~ch_cnt;
        end
    end

    assign pipe[0] = '{data: bus.d, valid: bus.dv, ch: bus.n & ch_cnt};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        comb64_stage u_stage (
            .clk (clk),
            .rst (rst),
            .n   (bus.n),
            .x   (pipe[i]),
            .y   (pipe[i+1])
        );
    end

    // Output register: width reduction, valid and channel tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_o   <= '0;
            qv_o  <= 1'b0;
            qch_o <= 1'b0;
        end else begin
            qv_o  <= pipe[STAGES].valid;
            qch_o <= pipe[STAGES].ch;
            if (pipe[STAGES].valid) begin
                q_o <= reduce_q(pipe[STAGES].data);
            end
        end
    end

    assign bus.q   = q_o;
    assign bus.qv  = qv_o;
    assign bus.qch = qch_o;

endmodule

// File: tb/tb_comb64.sv
// tb_comb64: four comb64 instances (S=1/OW=64, S=2/OW=64, S=4/OW=24,
// S=1/OW=8) fed from one stimulus stream, each checked every cycle against
// a binomial-sum reference of the comb cascade, plus literal expectations.
module tb_comb64;

    localparam int S_OF  [4] = '{1, 2, 4, 1};
    localparam int OW_OF [4] = '{64, 64, 24, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv  = 1'b0;
    logic        n   = 1'b0;
    logic [63:0] d   = '0;

    always #5 clk = ~clk;

    comb64_if #(.OW(64)) if1 ();
    comb64_if #(.OW(64)) if2 ();
    comb64_if #(.OW(24)) if4 ();
    comb64_if #(.OW(8))  if8 ();

    assign if1.d = d;  assign if1.dv = dv;  assign if1.n = n;
    assign if2.d = d;  assign if2.dv = dv;  assign if2.n = n;
    assign if4.d = d;  assign if4.dv = dv;  assign if4.n = n;
    assign if8.d = d;  assign if8.dv = dv;  assign if8.n = n;

    comb64 #(.STAGES(1), .OW(64)) u1 (.clk(clk), .rst(rst), .bus(if1));
    comb64 #(.STAGES(2), .OW(64)) u2 (.clk(clk), .rst(rst), .bus(if2));
    comb64 #(.STAGES(4), .OW(24)) u4 (.clk(clk), .rst(rst), .bus(if4));
    comb64 #(.STAGES(1), .OW(8))  u8 (.clk(clk), .rst(rst), .bus(if8));

    logic [63:0] dq   [4];
    logic        dqv  [4];
    logic        dqch [4];
    assign dq[0] = if1.q;           assign dqv[0] = if1.qv;  assign dqch[0] = if1.qch;
    assign dq[1] = if2.q;           assign dqv[1] = if2.qv;  assign dqch[1] = if2.qch;
    assign dq[2] = {40'd0, if4.q};  assign dqv[2] = if4.qv;  assign dqch[2] = if4.qch;
    assign dq[3] = {56'd0, if8.q};  assign dqv[3] = if8.qv;  assign dqch[3] = if8.qch;

    int nchk  = 0;
    int nfail = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [63:0] q;
        logic        ch;
    } exp_t;

    exp_t        expq  [4][$];
    logic [63:0] log_q [4][$];
    logic        log_ch[4][$];
    logic [63:0] hist  [2][7];
    int          ecnt  = 0;
    logic        chc   = 1'b0;
    logic        armed = 1'b0;

    function automatic int binom(input int s, input int j);
        int r = 1;
        for (int k = 1; k <= j; k++) r = r * (s - k + 1) / k;
        return r;
    endfunction

    // S-th order difference of the channel history: sum (-1)^j C(S,j) x[-j]
    function automatic logic [63:0] comb_of(input int c, input int s);
        logic [63:0] y = '0;
        logic [63:0] t;
        for (int j = 0; j <= s; j++) begin
            t = 64'(binom(s, j)) * hist[c][j];
            if (j % 2 == 1) y = y - t;
            else            y = y + t;
        end
        return y;
    endfunction

    function automatic logic [63:0] reduce(input logic [63:0] y, input int ow);
        logic signed [65:0] w;
        logic signed [65:0] r;
        logic signed [65:0] maxp;
        if (ow == 64) return y;
        w = {{2{y[63]}}, y};
`ifdef COMB64_ROUND_EN
        r    = (w + (66'sd1 <<< (63 - ow))) >>> (64 - ow);
        maxp = (66'sd1 <<< (ow - 1)) - 66'sd1;
        if (r > maxp) r = maxp;
`else
        r    = w >>> (64 - ow);
        maxp = '0;
`endif
        return r[63:0] & ((64'd1 << ow) - 64'd1);
    endfunction

    always @(posedge clk) begin
        int c;
        ecnt = ecnt + 1;
        if (rst) begin
            armed = 1'b1;
            chc   = 1'b0;
            for (int a = 0; a < 2; a++)
                for (int j = 0; j < 7; j++) hist[a][j] = '0;
            for (int i = 0; i < 4; i++) expq[i].delete();
        end else if (dv) begin
            c = n ? int'(chc) : 0;
            for (int j = 6; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = d;
            for (int i = 0; i < 4; i++)
                expq[i].push_back('{due: ecnt + S_OF[i], q: reduce(comb_of(c, S_OF[i]), OW_OF[i]), ch: c[0]});
            if (n) chc = ~chc;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic ev;
        if (armed) begin
            for (int i = 0; i < 4; i++) begin
                ev = (expq[i].size() > 0) && (expq[i][0].due == ecnt);
                nchk++;
                if (dqv[i] !== ev) begin
                    nfail++;
                    $display("FAIL u%0d qv @edge %0d: got %b expected %b", i, ecnt, dqv[i], ev);
                end
                if (ev) begin
                    nchk++;
                    if (dq[i] !== expq[i][0].q) begin
                        nfail++;
                        $display("FAIL u%0d q @edge %0d: got %h expected %h", i, ecnt, dq[i], expq[i][0].q);
                    end
                    nchk++;
                    if (dqch[i] !== expq[i][0].ch) begin
                        nfail++;
                        $display("FAIL u%0d qch @edge %0d: got %b expected %b", i, ecnt, dqch[i], expq[i][0].ch);
                    end
                    void'(expq[i].pop_front());
                end
                if (dqv[i] === 1'b1) begin
                    log_q[i].push_back(dq[i]);
                    log_ch[i].push_back(dqch[i]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic r, input logic v, input logic [63:0] x);
        @(negedge clk);
        rst = r;
        dv  = v;
        d   = x;
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 1'b0, 64'd0);
    endtask

    task automatic do_reset(input logic nm);
        @(negedge clk);
        rst = 1'b1;
        dv  = 1'b0;
        n   = nm;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 4; i++) begin
            log_q[i].delete();
            log_ch[i].delete();
        end
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_log(input int id, input int idx, input logic [63:0] eq, input logic ech, input string name);
        nchk++;
        if (idx >= log_q[id].size()) begin
            nfail++;
            $display("FAIL %s[%0d]: got no output expected q=%h", name, idx, eq);
        end else if (log_q[id][idx] !== eq || log_ch[id][idx] !== ech) begin
            nfail++;
            $display("FAIL %s[%0d]: got q=%h ch=%b expected q=%h ch=%b",
                     name, idx, log_q[id][idx], log_ch[id][idx], eq, ech);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s u%0d q", name, i), dq[i], 64'd0);
            check_eq($sformatf("%s u%0d qv", name, i), {63'd0, dqv[i]}, 64'd0);
            check_eq($sformatf("%s u%0d qch", name, i), {63'd0, dqch[i]}, 64'd0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] v8;

        do_reset(1'b0);
        #1 check_zero_outputs("reset");

        // S=1: first difference; S=2 uses the same stream under the model
        clear_logs();
        cycle(0, 1, 64'd0); cycle(0, 1, 64'd5); cycle(0, 1, 64'd12); cycle(0, 1, 64'd12);
        idle(8);
        check_eq("p1 count", 64'(log_q[0].size()), 64'd4);
        check_log(0, 0, 64'd0, 1'b0, "p1");
        check_log(0, 1, 64'd5, 1'b0, "p1");
        check_log(0, 2, 64'd7, 1'b0, "p1");
        check_log(0, 3, 64'd0, 1'b0, "p1");

        // S=2 on squares, back-to-back then with 3-cycle gaps
        for (int g = 0; g < 2; g++) begin
            do_reset(1'b0);
            clear_logs();
            for (int k = 0; k < 5; k++) begin
                cycle(0, 1, 64'(k * k));
                if (g == 1) idle(3);
            end
            idle(8);
            check_log(1, 0, 64'd0, 1'b0, $sformatf("p2g%0d", g));
            check_log(1, 1, 64'd1, 1'b0, $sformatf("p2g%0d", g));
            for (int k = 2; k < 5; k++) check_log(1, k, 64'd2, 1'b0, $sformatf("p2g%0d", g));
        end

        // two interleaved channels
        do_reset(1'b1);
        clear_logs();
        cycle(0, 1, 64'd10); cycle(0, 1, 64'd100); cycle(0, 1, 64'd15); cycle(0, 1, 64'd130);
        idle(8);
        check_log(0, 0, 64'd10,  1'b0, "p3");
        check_log(0, 1, 64'd100, 1'b1, "p3");
        check_log(0, 2, 64'd5,   1'b0, "p3");
        check_log(0, 3, 64'd30,  1'b1, "p3");

        // modular wrap
        do_reset(1'b0);
        clear_logs();
        cycle(0, 1, 64'h7FFF_FFFF_FFFF_FFFF); cycle(0, 1, 64'h8000_0000_0000_0000);
        idle(8);
        check_log(0, 1, 64'd1, 1'b0, "p4 wrap");

        // output reduction to 8 bits
        do_reset(1'b0);
        clear_logs();
        cycle(0, 1, 64'h0180_0000_0000_0000);
        idle(6);
`ifdef COMB64_ROUND_EN
        v8 = 64'h02;
`else
        v8 = 64'h01;
`endif
        check_log(3, 0, v8, 1'b0, "p5 round");
        do_reset(1'b0);
        clear_logs();
        cycle(0, 1, 64'h7F80_0000_0000_0000);
        idle(6);
        check_log(3, 0, 64'h7F, 1'b0, "p6 clamp");

        // reset mid-stream with samples in flight and dv coincident with rst
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) cycle(0, 1, 64'(1000 + k));
        cycle(1, 1, 64'd99);
        @(posedge clk);
        #1 check_zero_outputs("midrst");
        clear_logs();
        cycle(0, 1, 64'd42);
        idle(8);
        check_eq("p7 count", 64'(log_q[0].size()), 64'd1);
        check_log(0, 0, 64'd42, 1'b0, "p7");

        // randomized streams in both channel modes, occasional reset pulses
        for (int m = 0; m < 2; m++) begin
            do_reset(m[0]);
            for (int k = 0; k < 400; k++) begin
                cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                      {$urandom(), $urandom()});
            end
            idle(8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
